// File: rtl/peak_scan_ctrl.sv
// Round-robin peak scanner: one shared peak-hold datapath visits each enabled channel,
// discards SETTLE samples, holds the signed max over DWELL samples, then offers the result.
//   state    | meaning
//   S_IDLE   | not scanning; sel holds the last channel
//   S_SETTLE | discarding samples after a channel switch
//   S_ACQ    | tracking the signed maximum of in[sel]
module peak_scan_ctrl #(
  parameter int NCH    = 4,
  parameter int DWELL  = 3000,
  parameter int SETTLE = 4,
  localparam int SW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [NCH-1:0]    chmask_i,
  input  logic [NCH*16-1:0] in_i,
  output logic [SW-1:0]     sel_o,
  output logic              busy_o,
  output logic [15:0]       res_data_o,
  output logic [SW-1:0]     res_ch_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              ovf_o
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [SW-1:0] LAST_RST    = SW'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACQ} state_t;

  state_t             state_q;
  logic [SW-1:0]      sel_q, last_q, res_ch_q;
  logic [TW-1:0]      set_cnt_q;
  logic [DW-1:0]      acq_cnt_q;
  logic signed [15:0] peak_q, res_data_q;
  logic               busy_q, res_valid_q, ovf_q;

  logic [SW-1:0]      pick_d;
  logic               pick_ok_d;
  logic signed [15:0] samp_d, cand_d;
  logic               win_end_d, launch_d;

  // Walk offsets from far to near so the nearest enabled channel after last_q wins.
  always_comb begin
    pick_d    = last_q;
    pick_ok_d = |chmask_i;
    for (int i = NCH; i >= 1; i--) begin
      if (chmask_i[SW'((int'(last_q) + i) % NCH)]) pick_d = SW'((int'(last_q) + i) % NCH);
    end
  end

  assign samp_d    = in_i[sel_q*16 +: 16];
  assign cand_d    = (acq_cnt_q == '0 || samp_d > peak_q) ? samp_d : peak_q;
  assign win_end_d = (state_q == S_ACQ) && en_i && (acq_cnt_q == DWELL_LAST);
  assign launch_d  = en_i && pick_ok_d && (state_q == S_IDLE || win_end_d);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      last_q      <= LAST_RST;
      set_cnt_q   <= '0;
      acq_cnt_q   <= '0;
      peak_q      <= '0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (res_valid_q && res_ready_i) res_valid_q <= 1'b0;

      if (launch_d) begin
        sel_q     <= pick_d;
        last_q    <= pick_d;
        set_cnt_q <= '0;
        acq_cnt_q <= '0;
        busy_q    <= 1'b1;
        state_q   <= (SETTLE == 0) ? S_ACQ : S_SETTLE;
      end else begin
        case (state_q)
          S_SETTLE: begin
            if (!en_i) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (set_cnt_q == SETTLE_LAST) begin
              state_q   <= S_ACQ;
              acq_cnt_q <= '0;
            end else begin
              set_cnt_q <= set_cnt_q + 1'b1;
            end
          end
          S_ACQ: begin
            if (!en_i || win_end_d) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              peak_q    <= cand_d;
              acq_cnt_q <= acq_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end

      // A finished window either lands in a free (or freeing) slot or is dropped.
      if (win_end_d) begin
        if (!res_valid_q || res_ready_i) begin
          res_data_q  <= cand_d;
          res_ch_q    <= sel_q;
          res_valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign sel_o       = sel_q;
  assign busy_o      = busy_q;
  assign res_data_o  = res_data_q;
  assign res_ch_o    = res_ch_q;
  assign res_valid_o = res_valid_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Directed bench for peak_scan_ctrl (NCH=4, DWELL=8, SETTLE=2); results are matched
// against a scoreboard queue by an independent monitor on the falling edge.
`timescale 1ns/1ps
module tb_peak_scan_ctrl;
  localparam int NCH = 4, DWELL = 8, SETTLE = 2, SW = 2;

  logic              clk = 1'b0, rst = 1'b1, en = 1'b0, res_ready = 1'b0;
  logic [NCH-1:0]    chmask = '0;
  logic [NCH*16-1:0] in_v = '0;
  logic [SW-1:0]     sel, res_ch;
  logic              busy, res_valid, ovf;
  logic [15:0]       res_data;

  int vectors = 0, miscompares = 0, cyc = 0, ovf_cnt = 0;
  typedef struct {int ch; logic [15:0] data;} exp_t;
  exp_t sbq[$];
  int   pop_cyc[$];
  logic [15:0] neg_s [8];

  peak_scan_ctrl #(.NCH(NCH), .DWELL(DWELL), .SETTLE(SETTLE)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .chmask_i(chmask), .in_i(in_v),
    .sel_o(sel), .busy_o(busy), .res_data_o(res_data), .res_ch_o(res_ch),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .ovf_o(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_res(input int ch, input logic [15:0] d);
    exp_t e;
    e.ch = ch;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic set_in(input int ch, input logic [15:0] v);
    in_v[ch*16 +: 16] = v;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: inputs change just after posedge, so the negedge view equals what the next edge samples.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ovf) ovf_cnt++;
        if (res_valid && res_ready) begin
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got ch %0d data %0d, expected no result", res_ch, res_data);
          end else begin
            e = sbq.pop_front();
            check("res_ch", int'(res_ch), e.ch);
            check("res_data", int'(res_data), int'(e.data));
            pop_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    bit seen_busy, seen_valid;
    int base, ovf_base;
    neg_s = '{16'h8000, 16'hEC78, 16'hFF9C, 16'h8000, 16'hF830, 16'hFED4, 16'hFF9B, 16'h8001};

    // Reset and idle
    rst = 1'b1;
    run(10);
    check("rst_sel", int'(sel), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_ch", int'(res_ch), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    seen_busy = 0;
    seen_valid = 0;
    for (int i = 0; i < 50; i++) begin
      run(1);
      if (busy) seen_busy = 1;
      if (res_valid) seen_valid = 1;
    end
    check("idle_busy", int'(seen_busy), 0);
    check("idle_res_valid", int'(seen_valid), 0);

    // Single window on ch0: settle samples of 1000 must be ignored
    chmask = 4'b0001;
    res_ready = 1'b1;
    en = 1'b1;
    expect_res(0, 16'd9);
    run(1);
    check("s2_busy", int'(busy), 1);
    check("s2_sel", int'(sel), 0);
    set_in(0, 16'd1000); run(1);
    set_in(0, 16'd1000); run(1);
    for (int k = 0; k < 8; k++) begin
      set_in(0, 16'(-5 + 2 * k));
      run(1);
      if (k == 6) check("s2_early_valid", int'(res_valid), 0);
    end
    check("s2_res_valid", int'(res_valid), 1);
    check("s2_res_ch", int'(res_ch), 0);
    check("s2_res_data", int'(res_data), 9);
    en = 1'b0;
    run(3);
    check("s2_busy_after", int'(busy), 0);

    // Round-robin over ch1/ch3, then mask switch to ch2 mid-window
    chmask = 4'b1010;
    set_in(1, 16'h1111);
    set_in(3, 16'hFFFE);
    expect_res(1, 16'h1111); expect_res(3, 16'hFFFE);
    expect_res(1, 16'h1111); expect_res(3, 16'hFFFE);
    expect_res(1, 16'h1111); expect_res(2, 16'h0222);
    base = pop_cyc.size();
    en = 1'b1;
    run(45);
    chmask = 4'b0100;
    set_in(2, 16'h0222);
    run(16);
    check("s3_sel", int'(sel), 2);
    en = 1'b0;
    run(3);
    check("s3_pop_count", pop_cyc.size() - base, 6);
    for (int i = base + 1; i < pop_cyc.size(); i++)
      check("s3_spacing", pop_cyc[i] - pop_cyc[i-1], 10);

    // Backpressure: held result, dropped second window, ready on the window-end edge
    ovf_base = ovf_cnt;
    res_ready = 1'b0;
    chmask = 4'b0001;
    set_in(0, 16'd50);
    expect_res(0, 16'd50);
    expect_res(0, 16'd70);
    en = 1'b1;
    run(11);
    check("s4_valid_a", int'(res_valid), 1);
    check("s4_data_a", int'(res_data), 50);
    check("s4_ovf_a", int'(ovf), 0);
    set_in(0, 16'd60);
    run(10);
    check("s4_ovf_b", int'(ovf), 1);
    check("s4_data_held", int'(res_data), 50);
    check("s4_valid_held", int'(res_valid), 1);
    run(1);
    check("s4_ovf_one_cycle", int'(ovf), 0);
    set_in(0, 16'd70);
    run(8);
    res_ready = 1'b1;
    run(1);
    check("s4_valid_c", int'(res_valid), 1);
    check("s4_data_c", int'(res_data), 70);
    check("s4_ovf_c", int'(ovf), 0);
    en = 1'b0;
    run(3);
    check("s4_ovf_total", ovf_cnt - ovf_base, 1);

    // Negative peaks on ch1, abort during ch2 acquisition, resume at ch3
    ovf_base = ovf_cnt;
    chmask = 4'b1111;
    expect_res(1, 16'hFF9C);
    en = 1'b1;
    run(1);
    check("s5_sel", int'(sel), 1);
    set_in(1, 16'hFF6A); run(2);
    for (int k = 0; k < 8; k++) begin
      set_in(1, neg_s[k]);
      run(1);
    end
    run(4);
    en = 1'b0;
    run(1);
    check("s5_abort_busy", int'(busy), 0);
    check("s5_abort_sel", int'(sel), 2);
    run(3);
    check("s5_abort_valid", int'(res_valid), 0);
    check("s5_abort_ovf", ovf_cnt - ovf_base, 0);
    set_in(3, 16'h0333);
    expect_res(3, 16'h0333);
    en = 1'b1;
    run(1);
    check("s5_resume_sel", int'(sel), 3);
    check("s5_resume_busy", int'(busy), 1);
    run(10);
    en = 1'b0;
    run(3);

    // Asynchronous reset mid-acquisition with a result pending
    res_ready = 1'b0;
    chmask = 4'b1111;
    en = 1'b1;
    run(1);
    check("s6_sel", int'(sel), 1);
    run(10);
    check("s6_pending", int'(res_valid), 1);
    run(4);
    #3 rst = 1'b1;
    #1;
    check("s6_rst_sel", int'(sel), 0);
    check("s6_rst_busy", int'(busy), 0);
    check("s6_rst_valid", int'(res_valid), 0);
    check("s6_rst_ch", int'(res_ch), 0);
    check("s6_rst_data", int'(res_data), 0);
    en = 1'b0;
    run(1);
    rst = 1'b0;
    run(1);
    en = 1'b1;
    run(1);
    check("s6_restart_sel", int'(sel), 0);
    check("s6_restart_busy", int'(busy), 1);
    en = 1'b0;
    run(3);
    res_ready = 1'b1;
    run(2);
    check("scoreboard_drain", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/peak_scan_ctrl.md
# peak_scan_ctrl

Time-multiplexed peak-measurement scheduler: scans NCH signed 16-bit sample channels round-robin, measures each enabled channel's signed maximum over a fixed DWELL-cycle window after a SETTLE-cycle discard interval, and presents one result at a time on a valid/ready port. It shares one peak-hold datapath among all channels. It sits between the multi-channel sample bus and the readout/telemetry logic.

## Interface
- NCH, 4: number of input channels; NCH ≥ 1.
- DWELL, 3000: acquisition window length per channel, in cycles; DWELL ≥ 1.
- SETTLE, 4: samples discarded after each channel switch; SETTLE ≥ 0 (0 = acquire immediately).
- SW: derived, max(1, clog2(NCH)); channel index width.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable.
- chmask  in  NCH  per-channel enable; bit k enables channel k.
- in  in  NCH*16  packed signed samples; channel k at [k*16 +: 16].
- sel  out  SW  channel currently being measured.
- busy  out  1  high in SETTLE or ACQ.
- res_data  out  16  signed peak of the completed window.
- res_ch  out  SW  channel the result belongs to.
- res_valid  out  1  result held until accepted.
- res_ready  in  1  consumer accepts when res_valid & res_ready at an edge.
- ovf  out  1  one-cycle pulse: completed result dropped because output slot full.

## Operation
- FSM states: IDLE, SETTLE, ACQ.
- Channel pick: first channel with chmask bit set, searching from (last_served+1) mod NCH upward with wrap. last_served resets to NCH-1, so the first pick searches from channel 0. With one enabled channel, it is re-picked every window. chmask is sampled only at pick time.
- IDLE: if en=1 and chmask≠0, pick channel → sel, last_served := pick, go to SETTLE (or ACQ if SETTLE=0). Otherwise stay; sel holds.
- SETTLE: count SETTLE sampled edges, ignoring in[sel], then go to ACQ.
- ACQ: the first ACQ sample loads peak; subsequent samples do peak := max(peak, in[sel]), signed 16-bit compare. No width growth or saturation.
- Window end (DWELL-th ACQ sample):
  - The final candidate is max(peak, that sample).
  - If res_valid=0, or res_valid & res_ready at this edge, load res_data/res_ch and set res_valid=1.
  - Otherwise drop the result, pulse ovf for one cycle, and leave the held result unchanged.
- After window end:
  - If en=1 and chmask≠0, pick the next channel and go straight to SETTLE/ACQ (no IDLE cycle).
  - Otherwise go to IDLE.
- en=0 sampled in SETTLE or ACQ: abort → IDLE at that edge. No result, no ovf. last_served keeps the aborted channel.
- res_valid clears on acceptance unless a new result loads at the same edge (load wins; valid stays 1).
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any pending result is lost.

## Timing
- Reset values: sel=0, busy=0, res_data=0, res_ch=0, res_valid=0, ovf=0, state=IDLE, counters=0.
- en=1 sampled at edge E0: after E0, busy=1 and sel=pick.
- Edges E1..E_SETTLE: samples discarded.
- Edges E_SETTLE+1..E_SETTLE+DWELL: samples accumulated.
- After edge E_SETTLE+DWELL: res_valid=1 (slot free) and sel moves to the next channel.
- Steady-state throughput: one window per SETTLE+DWELL cycles. busy stays 1 between back-to-back windows.
- sel changes only at pick edges; outputs are registered, with no combinational path from in to outputs.
- ovf is high for exactly the cycle after the dropping edge.
- Counters are clog2-sized for DWELL and SETTLE and reset to 0 at each phase entry.

## Test plan
Parameters for all scenarios: NCH=4, DWELL=8, SETTLE=2.
- Reset/idle: hold rst 10 cycles with en=0 → all outputs 0. Hold en=0 for 50 cycles → busy=0, res_valid never asserts.
- Single window: chmask=4'b0001, in0 ramps -5,-3,…,+9 then constant; res_ready=1.
  - Expect res_valid 11 cycles after en rises (1 pick + SETTLE 2 + DWELL 8), res_ch=0.
  - res_data = max of the 8 acquired samples only; settle samples are excluded even if larger (set a settle sample to +1000 to check).
- Round-robin and mask: chmask=4'b1010, channels at constants 0x1111 (ch1) and -2 (ch3), res_ready=1.
  - Expect res_ch sequence 1,3,1,3, with results 10 cycles apart and res_data 0x1111 / 0xFFFE.
  - Change chmask to 4'b0100 mid-window → the current window finishes, then ch2 is measured.
- Backpressure/overflow: res_ready=0, chmask=4'b0001.
  - First result held; ovf pulses once 10 cycles later; res_data unchanged.
  - Assert res_ready on the exact window-end edge → new result loaded, res_valid stays 1, no ovf.
- Abort and negative peaks: all samples -32768..-100, one window → res_data = -100 (signed compare).
  - Drop en during ACQ → IDLE next cycle, busy=0, no result, no ovf.
  - Re-enable → next channel after the aborted one.
- Async reset mid-ACQ: assert rst between clock edges → outputs zero immediately; scan restarts at channel 0 after release.
